// File: rtl/decode_stage_pipe_if.sv
// Handshake and decoded-bundle bus between fetch, decode stage and execute.
// master = upstream/downstream environment, slave = the decode stage itself.
interface decode_stage_pipe_if #(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) ();
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instruction;
    logic                out_valid;
    logic                out_ready;
    logic                branch_enable;
    logic                jump;
    logic                jump_reg;
    logic                pc_to_alu;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                alu_inv_zero;
    logic                mem_read;
    logic                mem_write_enable;
    logic [1:0]          mem_size;
    logic                mem_unsigned;
    logic                mem_to_reg;
    logic                reg_write_enable;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                ill_instr;
    logic [CNT_W-1:0]    ill_count;
    logic [CNT_W-1:0]    bubble_count;

    modport master (
        output flush, in_valid, instruction, out_ready,
        input  in_ready, out_valid, branch_enable, jump, jump_reg, pc_to_alu, alu_op, alu_src,
               alu_inv_zero, mem_read, mem_write_enable, mem_size, mem_unsigned, mem_to_reg,
               reg_write_enable, rd, rs1, rs2, ill_instr, ill_count, bubble_count
    );

    modport slave (
        input  flush, in_valid, instruction, out_ready,
        output in_ready, out_valid, branch_enable, jump, jump_reg, pc_to_alu, alu_op, alu_src,
               alu_inv_zero, mem_read, mem_write_enable, mem_size, mem_unsigned, mem_to_reg,
               reg_write_enable, rd, rs1, rs2, ill_instr, ill_count, bubble_count
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered RV32I decode stage with valid/ready handshake, flush, load-use interlock
// and saturating illegal-instruction / bubble counters.
module decode_stage_pipe #(
    parameter int ALU_OP_W  = 4,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    decode_stage_pipe_if.slave  bus
);
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 7;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 8;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 9;
    localparam logic [ALU_OP_W-1:0] ALU_PASS_1 = 10;

    typedef struct packed {
        logic                branch_enable;
        logic                jump;
        logic                jump_reg;
        logic                pc_to_alu;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                alu_inv_zero;
        logic                mem_read;
        logic                mem_write_enable;
        logic [1:0]          mem_size;
        logic                mem_unsigned;
        logic                mem_to_reg;
        logic                reg_write_enable;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic                ill_instr;
    } bundle_t;

    function automatic logic [ALU_OP_W-1:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    endfunction

    bundle_t     r_b;
    logic        r_valid;
    logic [CNT_W-1:0] r_ill_cnt, r_bub_cnt;

    bundle_t     w_dec;
    logic        w_ill, w_use_rs1, w_use_rs2, w_hazard, w_in_ready, w_accept;
    logic [6:0]  w_opc, w_f7;
    logic [2:0]  w_f3;

    assign w_opc = bus.instruction[6:0];
    assign w_f3  = bus.instruction[14:12];
    assign w_f7  = bus.instruction[31:25];

    always_comb begin
        w_dec     = '0;
        w_ill     = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_dec.rd  = bus.instruction[11:7];
        w_dec.rs1 = bus.instruction[19:15];
        case (w_opc)
            7'b0110011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ill = !(w_f7 == 7'b0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
                w_dec.alu_op           = alu_fn(w_f3, w_f7[5]);
                w_dec.reg_write_enable = 1'b1;
            end
            7'b0010011: begin
                w_use_rs1 = 1'b1;
                if (w_f3 == 3'b001)
                    w_ill = (w_f7 != 7'b0);
                else if (w_f3 == 3'b101)
                    w_ill = !(w_f7 == 7'b0 || w_f7 == 7'b0100000);
                // only shifts carry funct7; addi's imm[10] must not turn it into sub
                w_dec.alu_op           = alu_fn(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                w_dec.alu_src          = 1'b1;
                w_dec.reg_write_enable = 1'b1;
            end
            7'b0110111: begin
                w_dec.alu_op           = ALU_PASS_1;
                w_dec.alu_src          = 1'b1;
                w_dec.reg_write_enable = 1'b1;
            end
            7'b0010111: begin
                w_dec.alu_op           = ALU_ADD;
                w_dec.alu_src          = 1'b1;
                w_dec.pc_to_alu        = 1'b1;
                w_dec.reg_write_enable = 1'b1;
            end
            7'b1101111: begin
                w_dec.jump             = 1'b1;
                w_dec.reg_write_enable = 1'b1;
            end
            7'b1100111: begin
                w_use_rs1 = 1'b1;
                w_ill     = (w_f3 != 3'b000);
                w_dec.jump             = 1'b1;
                w_dec.jump_reg         = 1'b1;
                w_dec.alu_op           = ALU_ADD;
                w_dec.alu_src          = 1'b1;
                w_dec.reg_write_enable = 1'b1;
            end
            7'b1100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ill     = (w_f3[2:1] == 2'b01);
                w_dec.branch_enable = 1'b1;
                w_dec.alu_op        = !w_f3[2] ? ALU_SUB : (w_f3[1] ? ALU_SLTU : ALU_SLT);
                // bne/blt/bltu take the branch on a non-zero ALU result
                w_dec.alu_inv_zero  = w_f3[2] ? !w_f3[0] : w_f3[0];
            end
            7'b0000011: begin
                w_use_rs1 = 1'b1;
                w_ill     = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
                w_dec.mem_read         = 1'b1;
                w_dec.mem_to_reg       = 1'b1;
                w_dec.alu_op           = ALU_ADD;
                w_dec.alu_src          = 1'b1;
                w_dec.mem_size         = w_f3[1:0];
                w_dec.mem_unsigned     = w_f3[2];
                w_dec.reg_write_enable = 1'b1;
            end
            7'b0100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ill     = w_f3[2] || (w_f3[1:0] == 2'b11);
                w_dec.mem_write_enable = 1'b1;
                w_dec.alu_op           = ALU_ADD;
                w_dec.alu_src          = 1'b1;
                w_dec.mem_size         = w_f3[1:0];
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_dec           = '0;
            w_dec.ill_instr = 1'b1;
            w_use_rs1       = 1'b0;
            w_use_rs2       = 1'b0;
        end
        w_dec.rs2              = w_use_rs2 ? bus.instruction[24:20] : 5'd0;
        w_dec.reg_write_enable = w_dec.reg_write_enable && (w_dec.rd != 5'd0);
    end

    assign w_hazard = (HAZARD_EN != 0) && r_valid && r_b.mem_read && (r_b.rd != 5'd0) && bus.in_valid &&
                      ((w_use_rs1 && w_dec.rs1 == r_b.rd) || (w_use_rs2 && w_dec.rs2 == r_b.rd));
    assign w_in_ready = !rst && !bus.flush && (!r_valid || bus.out_ready) && !w_hazard;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_b       <= '0;
            r_ill_cnt <= '0;
            r_bub_cnt <= '0;
        end else begin
            if (bus.flush)
                r_valid <= 1'b0;
            else if (w_accept) begin
                r_b     <= w_dec;
                r_valid <= 1'b1;
            end else if (bus.out_ready)
                r_valid <= 1'b0;
            if (w_accept && w_dec.ill_instr && r_ill_cnt != '1)
                r_ill_cnt <= r_ill_cnt + 1'b1;
            if (w_hazard && bus.out_ready && r_valid && r_bub_cnt != '1)
                r_bub_cnt <= r_bub_cnt + 1'b1;
        end
    end

    assign bus.in_ready         = w_in_ready;
    assign bus.out_valid        = r_valid;
    assign bus.branch_enable    = r_b.branch_enable;
    assign bus.jump             = r_b.jump;
    assign bus.jump_reg         = r_b.jump_reg;
    assign bus.pc_to_alu        = r_b.pc_to_alu;
    assign bus.alu_op           = r_b.alu_op;
    assign bus.alu_src          = r_b.alu_src;
    assign bus.alu_inv_zero     = r_b.alu_inv_zero;
    assign bus.mem_read         = r_b.mem_read;
    assign bus.mem_write_enable = r_b.mem_write_enable;
    assign bus.mem_size         = r_b.mem_size;
    assign bus.mem_unsigned     = r_b.mem_unsigned;
    assign bus.mem_to_reg       = r_b.mem_to_reg;
    assign bus.reg_write_enable = r_b.reg_write_enable;
    assign bus.rd               = r_b.rd;
    assign bus.rs1              = r_b.rs1;
    assign bus.rs2              = r_b.rs2;
    assign bus.ill_instr        = r_b.ill_instr;
    assign bus.ill_count        = r_ill_cnt;
    assign bus.bubble_count     = r_bub_cnt;
endmodule
